// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter and its datapath users.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    // Word accesses only: an odd byte address can never be serviced.
    function automatic logic misaligned(input logic lsb);
        return lsb;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and backing-memory signals seen by the arbiter.
// slave: the arbiter's view; master: the requesters' and memory's view.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              halt;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_stall;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_stall;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              err;
    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  halt, if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_stall, if_done, if_rdata, d_stall, d_done, d_rdata, err,
               mem_req, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output halt, if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_stall, if_done, if_rdata, d_stall, d_done, d_rdata, err,
               mem_req, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_watchdog_ctr.sv
// Counts cycles spent waiting on the memory; expired_o flags the last allowed cycle.
module watchdog_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturate at the terminal count so a stuck enable cannot wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single backing memory between instruction fetch and data access.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate, or complete a faulting request
// BUSY_I | fetch read outstanding, mem_req held until ack or watchdog expiry
// BUSY_D | data load/store outstanding, mem_req held until ack or watchdog expiry
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.slave    bus
);

    arb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              last_d_q, last_d_d;

    logic d_pend, i_pend, grant_d, grant_i, d_fault, i_fault;
    logic wd_clr, wd_en, wd_expired;

    watchdog_ctr #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    assign wd_clr = (state_q == IDLE);
    assign wd_en  = (state_q == BUSY_I) || (state_q == BUSY_D);

    // A port whose done is showing this cycle still holds its old request; mask it
    // so the same request is not granted twice.
    assign d_pend  = (bus.d_rd | bus.d_wr) & ~d_done_q;
    assign i_pend  = bus.if_req & ~bus.halt & ~if_done_q;
    assign grant_d = d_pend & (~i_pend | ~last_d_q);
    assign grant_i = i_pend & ~grant_d;
    assign d_fault = (bus.d_rd & bus.d_wr) | misaligned(bus.d_addr[0]);
    assign i_fault = misaligned(bus.if_addr[0]);

    // Arbitration, memory handshake and completion next-state logic.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        err_d       = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        last_d_d    = last_d_q;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    last_d_d = PORT_D;
                    if (d_fault) begin
                        d_done_d = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        state_d     = BUSY_D;
                        mem_req_d   = 1'b1;
                        mem_wr_d    = bus.d_wr;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                    end
                end else if (grant_i) begin
                    last_d_d = PORT_I;
                    if (i_fault) begin
                        if_done_d = 1'b1;
                        err_d     = 1'b1;
                    end else begin
                        state_d     = BUSY_I;
                        mem_req_d   = 1'b1;
                        mem_wr_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = bus.d_wdata;
                    end
                end
            end

            BUSY_I: begin
                // An ack in the expiry cycle still wins over the timeout.
                if (bus.mem_ack) begin
                    if_rdata_d = bus.mem_rdata;
                    if_done_d  = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                end else if (wd_expired) begin
                    if_done_d = 1'b1;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end

            BUSY_D: begin
                if (bus.mem_ack) begin
                    if (!mem_wr_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                    d_done_d  = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (wd_expired) begin
                    d_done_d  = 1'b1;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            last_d_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            last_d_q    <= last_d_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.err       = err_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_stall  = bus.if_req & ~if_done_q;
    assign bus.d_stall   = (bus.d_rd | bus.d_wr) & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, a small memory model,
// expected completions and memory accesses queued and checked by monitors.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          port;
        bit          err;
        logic [15:0] rdata;
        int          cyc;
    } done_t;

    typedef struct {
        logic [15:0] addr;
        bit          wr;
        logic [15:0] wdata;
    } acc_t;

    done_t dq[$];
    acc_t  aq[$];

    int mem_wait;
    bit mem_never;
    int n_rise;
    int n_req_hi;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void push_done(input bit port, input bit err, input logic [15:0] rdata, input int c);
        done_t e;
        e.port = port; e.err = err; e.rdata = rdata; e.cyc = c;
        dq.push_back(e);
    endfunction

    function automatic void push_acc(input logic [15:0] addr, input bit wr, input logic [15:0] wdata);
        acc_t e;
        e.addr = addr; e.wr = wr; e.wdata = wdata;
        aq.push_back(e);
    endfunction

    function automatic void check_done(input bit port, input bit err, input logic [15:0] rdata);
        done_t e;
        if (dq.size() == 0) begin
            chk(port ? "unexpected_d_done" : "unexpected_if_done", 1, 0);
        end else begin
            e = dq.pop_front();
            chk("done_port", 32'(port), 32'(e.port));
            chk("done_err", 32'(err), 32'(e.err));
            chk("done_rdata", 32'(rdata), 32'(e.rdata));
            if (e.cyc >= 0) chk("done_cycle", cyc, e.cyc);
        end
    endfunction

    // Memory model: read data is the address XOR 0xA5B5, ack after mem_wait cycles.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                wcnt = 0;
            end else if (bus.mem_req && !mem_never) begin
                if (wcnt >= mem_wait) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = bus.mem_addr ^ 16'hA5B5;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Completion monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.if_done) check_done(1'b0, bus.err, bus.if_rdata);
                if (bus.d_done)  check_done(1'b1, bus.err, bus.d_rdata);
                if (bus.err && !bus.if_done && !bus.d_done) chk("err_without_done", 1, 0);
            end
        end
    end

    // Memory access monitor.
    initial begin
        bit prev;
        acc_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_req) n_req_hi++;
            if (bus.mem_req && !prev) begin
                n_rise++;
                if (aq.size() == 0) begin
                    chk("unexpected_mem_req", 1, 0);
                end else begin
                    e = aq.pop_front();
                    chk("acc_addr", 32'(bus.mem_addr), 32'(e.addr));
                    chk("acc_wr", 32'(bus.mem_wr), 32'(e.wr));
                    if (e.wr) chk("acc_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
                end
            end
            prev = bus.mem_req;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_i(input logic [15:0] addr);
        bit got;
        got = 1'b0;
        bus.if_addr = addr;
        bus.if_req  = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.if_done) begin
                got = 1'b1;
                break;
            end
        end
        chk("if_done_seen", 32'(got), 1);
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
    endtask

    task automatic do_d(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] wdata);
        bit got;
        got = 1'b0;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        bus.d_rd    = rd;
        bus.d_wr    = wr;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.d_done) begin
                got = 1'b1;
                break;
            end
        end
        chk("d_done_seen", 32'(got), 1);
        @(posedge clk);
        #1;
        bus.d_rd = 1'b0;
        bus.d_wr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, 32'(bus.mem_req), 0);
        chk({tag, "_mem_wr"}, 32'(bus.mem_wr), 0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
        chk({tag, "_if_done"}, 32'(bus.if_done), 0);
        chk({tag, "_d_done"}, 32'(bus.d_done), 0);
        chk({tag, "_err"}, 32'(bus.err), 0);
        chk({tag, "_if_rdata"}, 32'(bus.if_rdata), 0);
        chk({tag, "_d_rdata"}, 32'(bus.d_rdata), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int h0;
        int r0;
        cyc = 0; n_cmp = 0; n_bad = 0; n_rise = 0; n_req_hi = 0;
        mem_wait = 0; mem_never = 1'b0;
        rst = 1'b1;
        bus.halt = 1'b0; bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_rd = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        idle(3);
        check_reset_outputs("reset");
        chk("reset_if_stall", 32'(bus.if_stall), 0);
        chk("reset_d_stall", 32'(bus.d_stall), 0);
        rst = 1'b0;
        idle(2);

        // Fetch only, zero-wait memory.
        c0 = cyc;
        push_acc(16'h0010, 1'b0, 16'h0000);
        push_done(1'b0, 1'b0, 16'hA5A5, c0 + 2);
        bus.if_addr = 16'h0010;
        bus.if_req  = 1'b1;
        @(negedge clk); chk("if_stall_c0", 32'(bus.if_stall), 1);
        @(negedge clk); chk("if_stall_c1", 32'(bus.if_stall), 1);
        chk("mem_req_c1", 32'(bus.mem_req), 1);
        @(negedge clk); chk("if_stall_c2", 32'(bus.if_stall), 0);
        chk("if_done_c2", 32'(bus.if_done), 1);
        @(posedge clk); #1;
        bus.if_req = 1'b0;
        idle(2);

        // Simultaneous fetch and store after reset: store first, then fetch.
        rst = 1'b1; idle(2); rst = 1'b0; idle(1);
        c0 = cyc;
        push_acc(16'h0100, 1'b1, 16'h1234);
        push_acc(16'h0020, 1'b0, 16'h0000);
        push_done(1'b1, 1'b0, 16'h0000, c0 + 2);
        push_done(1'b0, 1'b0, 16'hA595, c0 + 4);
        fork
            do_i(16'h0020);
            do_d(1'b0, 1'b1, 16'h0100, 16'h1234);
        join
        idle(2);

        // Both ports continuously pending: grants alternate data/fetch.
        c0 = cyc;
        push_acc(16'h0200, 1'b0, 16'h0000);
        push_acc(16'h0030, 1'b0, 16'h0000);
        push_acc(16'h0202, 1'b0, 16'h0000);
        push_acc(16'h0032, 1'b0, 16'h0000);
        push_done(1'b1, 1'b0, 16'hA7B5, c0 + 2);
        push_done(1'b0, 1'b0, 16'hA585, c0 + 4);
        push_done(1'b1, 1'b0, 16'hA7B7, c0 + 6);
        push_done(1'b0, 1'b0, 16'hA587, c0 + 8);
        fork
            begin do_d(1'b1, 1'b0, 16'h0200, 16'h0); do_d(1'b1, 1'b0, 16'h0202, 16'h0); end
            begin do_i(16'h0030); do_i(16'h0032); end
        join
        idle(2);

        // Faults: misaligned load, read+write together, misaligned fetch.
        r0 = n_rise;
        c0 = cyc;
        push_done(1'b1, 1'b1, 16'hA7B7, c0 + 1);
        do_d(1'b1, 1'b0, 16'h0003, 16'h0);
        idle(1);
        c0 = cyc;
        push_done(1'b1, 1'b1, 16'hA7B7, c0 + 1);
        do_d(1'b1, 1'b1, 16'h0004, 16'h5555);
        idle(1);
        c0 = cyc;
        push_done(1'b0, 1'b1, 16'hA587, c0 + 1);
        do_i(16'h0011);
        idle(1);
        chk("fault_no_mem_req", n_rise - r0, 0);

        // Halt blocks fetch grants but not loads.
        bus.halt = 1'b1;
        c0 = cyc;
        r0 = n_rise;
        push_acc(16'h0040, 1'b0, 16'h0000);
        push_acc(16'h0050, 1'b0, 16'h0000);
        push_done(1'b1, 1'b0, 16'hA5F5, c0 + 12);
        push_done(1'b0, 1'b0, 16'hA5E5, c0 + 15);
        fork
            do_i(16'h0050);
            begin
                idle(10);
                chk("halt_no_grant", n_rise - r0, 0);
                chk("halt_if_stall", 32'(bus.if_stall), 1);
                do_d(1'b1, 1'b0, 16'h0040, 16'h0);
                bus.halt = 1'b0;
            end
        join
        idle(2);

        // Halt raised while a fetch is in flight: the fetch still completes.
        mem_wait = 3;
        c0 = cyc;
        push_acc(16'h0060, 1'b0, 16'h0000);
        push_done(1'b0, 1'b0, 16'hA5D5, c0 + 5);
        fork
            do_i(16'h0060);
            begin idle(2); bus.halt = 1'b1; end
        join
        bus.halt = 1'b0;
        mem_wait = 0;
        idle(2);

        // Watchdog: no ack at all, then ack in the expiry cycle.
        mem_never = 1'b1;
        c0 = cyc;
        h0 = n_req_hi;
        push_acc(16'h0070, 1'b0, 16'h0000);
        push_done(1'b1, 1'b1, 16'hA5F5, c0 + 5);
        do_d(1'b1, 1'b0, 16'h0070, 16'h0);
        chk("timeout_req_cycles", n_req_hi - h0, 4);
        mem_never = 1'b0;
        mem_wait = 3;
        idle(2);
        c0 = cyc;
        h0 = n_req_hi;
        push_acc(16'h0072, 1'b0, 16'h0000);
        push_done(1'b1, 1'b0, 16'hA5C7, c0 + 5);
        do_d(1'b1, 1'b0, 16'h0072, 16'h0);
        chk("late_ack_req_cycles", n_req_hi - h0, 4);
        idle(2);

        // Reset during a data access: request dropped, no completion.
        push_acc(16'h0080, 1'b0, 16'h0000);
        bus.d_addr = 16'h0080;
        bus.d_rd   = 1'b1;
        idle(2);
        chk("pre_rst_mem_req", 32'(bus.mem_req), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        bus.d_rd = 1'b0;
        idle(3);
        rst = 1'b0;
        mem_wait = 0;
        idle(2);
        c0 = cyc;
        push_acc(16'h0082, 1'b0, 16'h0000);
        push_done(1'b1, 1'b0, 16'hA537, c0 + 2);
        do_d(1'b1, 1'b0, 16'h0082, 16'h0);
        idle(3);

        chk("done_queue_empty", dq.size(), 0);
        chk("acc_queue_empty", aq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single multi-cycle backing memory between the fetch stage (read-only) and the memory stage (loads/stores) of the pipelined processor. Latches one request at a time, drives the memory handshake, returns read data and a completion pulse to the winning requester, and stalls the loser. The decoder's MemRead/MemWrite drive the data port, and its Halt gates further fetches.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- TIMEOUT, 64, max cycles `mem_req` may wait for `mem_ack` before abort (≥2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- halt  in  1  no new fetch grants while high
- if_req  in  1  fetch read request, level, held until `if_done`
- if_addr  in  ADDR_W  fetch address
- if_stall  out  1  `if_req` high and `if_done` low
- if_done  out  1  one-cycle completion pulse
- if_rdata  out  DATA_W  fetched word, held until next fetch completion
- d_rd  in  1  data read (MemRead), level, held until `d_done`
- d_wr  in  1  data write (MemWrite), level, held until `d_done`
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_stall  out  1  (`d_rd` or `d_wr`) high and `d_done` low
- d_done  out  1  one-cycle completion pulse
- d_rdata  out  DATA_W  load data, held until next data read completion
- err  out  1  one-cycle pulse coincident with the faulting port's done
- mem_req  out  1  memory request, held until `mem_ack`
- mem_wr  out  1  1 = write
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_ack  in  1  memory completion; read data valid same cycle
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: pending data (`d_rd|d_wr`) and pending fetch (`if_req & !halt`):
  - Both pending: grant goes to the port not granted last (`last_d` flag); after reset `last_d`=0, so data wins.
  - Only one pending: that port wins.
  - Grant latches addr, wdata and `mem_wr=d_wr`, then moves to BUSY_x.
- Data fault (`d_rd & d_wr`, or `d_addr[0]=1`) detected in IDLE when data would win: no memory access; next cycle `d_done=1`, `err=1`, `d_rdata` unchanged; stay in IDLE. Fetch fault (`if_addr[0]=1`) is handled the same way on the fetch port.
- BUSY_x: `mem_req=1`.
  - On `mem_ack`: register `mem_rdata` into x_rdata (reads only), pulse x_done next cycle, return to IDLE.
  - Watchdog counts cycles in BUSY. When the count reaches TIMEOUT without ack: drop `mem_req`, pulse x_done and err next cycle, return to IDLE.
- `halt` never aborts an in-flight fetch and never blocks data requests.
- `halt` is sampled only in IDLE.
- `mem_ack` outside BUSY is ignored.
- x_done drops the requester's stall in the same cycle. The requester may present a new request in the next cycle.

## Timing
- All outputs are registered except `if_stall`/`d_stall`, which are combinational from the requests and registered done.
- Reset values: state=IDLE, `mem_req`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0, all done=0, err=0, rdata=0, `last_d`=0, watchdog=0.
- Zero-wait latency:
  - Request in cycle 0.
  - Grant at edge 0→1; `mem_req` in cycle 1.
  - `mem_ack` in cycle 1.
  - done and rdata valid in cycle 2.
  - Minimum 2 cycles; W memory wait cycles add W.
- Fault completion: done/err in cycle 1.
- Back-to-back: a new grant is possible in the IDLE cycle that carries done, so issue is at most every 2 cycles.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles, then done/err on the next cycle.
- `mem_ack` in the same cycle the watchdog expires counts as success (no err).
- Reset mid-transfer: `mem_req` drops asynchronously and no done is issued. The backing memory tolerates an abandoned request.

## Structure
- Shared package:
  - state enum {IDLE, BUSY_I, BUSY_D}
  - port id constants PORT_I=0, PORT_D=1
  - ADDR_W/DATA_W defaults shared with the datapath
- Natural sub-module: `watchdog_ctr`, a $clog2(TIMEOUT+1)-bit counter with clear/enable and an `expired` output.
- Everything else lives in the `mem_arbiter` body.

## Test plan
- Fetch only, `if_addr`=0x0010, ack in cycle 1, `mem_rdata`=0xA5A5 → `if_done` in cycle 2, `if_rdata`=0xA5A5, `if_stall` high in cycles 0–1 only.
- Simultaneous fetch 0x0020 and store 0x0100/0x1234 after reset → store first (`mem_wr`=1, `mem_wdata`=0x1234). Fetch is granted in the IDLE cycle after `d_done`. Keep both requests pending and confirm grants alternate.
- `d_rd` with `d_addr`=0x0003 → `d_done` and err in cycle 1, `mem_req` never rises. Repeat with `d_rd=d_wr=1` → same.
- `halt`=1 with `if_req` pending → no fetch grant for 10 cycles. Load to 0x0040 still completes. Assert `halt` during BUSY_I → that fetch completes.
- TIMEOUT=4, `mem_ack` tied low → `mem_req` high for 4 cycles, then done+err, state IDLE. Repeat with ack on the 4th cycle → done, no err.
- Assert `rst` during BUSY_D with 3 wait cycles → `mem_req`=0 immediately, no `d_done`, all outputs at reset values. After release, a fresh load completes normally.
